// File: rtl/pll_reset_sequencer.sv
// Turns the PLL's asynchronous lock flag into the domain reset: assert async,
// release synchronously after a lock-qualification window plus a hold-off.
module pll_reset_sequencer #(
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       locked,
  input  logic       reset_request,
  output logic       reset,
  output logic [7:0] lock_loss_count
);

  localparam int MAXC = (LOCK_CYCLES > HOLD_CYCLES) ? LOCK_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {LOCK_WAIT, HOLD, RUN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            sync1_q, sync2_q;
  logic            reset_q, reset_d;
  logic [7:0]      llc_q, llc_d;
  logic            loss;
  logic            locked_s;

  assign locked_s        = sync2_q;
  assign reset           = reset_q;
  assign lock_loss_count = llc_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= LOCK_WAIT;
      cnt_q   <= '0;
      reset_q <= 1'b1;
      llc_q   <= '0;
    end else begin
      sync1_q <= locked;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reset_q <= reset_d;
      llc_q   <= llc_d;
    end
  end

  // Lock loss outranks a soft request, which outranks hold-off expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reset_d = reset_q;
    llc_d   = llc_q;
    loss    = 1'b0;
    case (state_q)
      LOCK_WAIT: begin
        reset_d = 1'b1;
        if (!locked_s)               cnt_d = '0;
        else if (cnt_q == LOCK_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else                     cnt_d = cnt_q + CW'(1);
      end
      HOLD: begin
        reset_d = 1'b1;
        if (!locked_s) begin
          state_d = LOCK_WAIT;
          cnt_d   = '0;
          loss    = 1'b1;
        end else if (reset_request)  cnt_d = '0;
        else if (cnt_q == HOLD_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
          reset_d = 1'b0;
        end else                     cnt_d = cnt_q + CW'(1);
      end
      RUN: begin
        reset_d = 1'b0;
        if (!locked_s) begin
          state_d = LOCK_WAIT;
          cnt_d   = '0;
          reset_d = 1'b1;
          loss    = 1'b1;
        end else if (reset_request) begin
          state_d = HOLD;
          cnt_d   = '0;
          reset_d = 1'b1;
        end
      end
      default: begin
        state_d = LOCK_WAIT;
        cnt_d   = '0;
        reset_d = 1'b1;
      end
    endcase
    if (loss && llc_q != 8'hFF) llc_d = llc_q + 8'd1;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the ECP5 PLL wrapper, in the PLL output clock domain.
- Consumes the PLL's asynchronous `locked` flag and produces the design-wide reset for that domain. Reset asserts asynchronously and releases synchronously, only after lock has been continuously stable for a qualification window plus a hold-off.
- Re-enters reset on any loss of lock and counts lock-loss events for debug.

Parameters:
- LOCK_CYCLES, 1024: consecutive synchronized-lock-high cycles required before the hold-off starts; minimum 1.
- HOLD_CYCLES, 16: cycles reset stays asserted after lock qualification; minimum 1.

Ports:
- clock  input  1  PLL output clock; all logic on its rising edge.
- reset_n  input  1  asynchronous active-low reset. Assertion is async. Deassertion is driven synchronous to clock by the board-level reset source.
- locked  input  1  PLL lock flag; asynchronous to clock.
- reset_request  input  1  synchronous soft-reset request, active high, single-cycle pulse or level.
- reset  output  1  active-high reset for downstream logic; driven by a dedicated flop, glitch-free.
- lock_loss_count  output  8  saturating count of lock-loss events since reset_n.

Behaviour:
- Async reset (reset_n low):
  - sync flops = 0, state = LOCK_WAIT, counter = 0.
  - reset = 1, lock_loss_count = 0.
- Lock synchronizer:
  - locked passes through 2 flops (sync1, sync2); locked_s = sync2.
  - No other logic samples raw locked.
- Counter:
  - Width $clog2(max(LOCK_CYCLES, HOLD_CYCLES)+1).
  - Shared by LOCK_WAIT and HOLD; cleared on every state change.
- State LOCK_WAIT (reset = 1):
  - locked_s = 0 -> counter cleared.
  - locked_s = 1 and counter != LOCK_CYCLES-1 -> counter++.
  - locked_s = 1 and counter == LOCK_CYCLES-1 -> HOLD, counter cleared.
  - reset_request is ignored here.
- State HOLD (reset = 1):
  - locked_s = 0 -> LOCK_WAIT, lock_loss_count++ (saturating).
  - Else reset_request = 1 -> counter cleared, stay in HOLD.
  - Else counter == HOLD_CYCLES-1 -> RUN; the reset flop loads 0 on the same edge.
  - Else counter++.
- State RUN (reset = 0):
  - locked_s = 0 -> LOCK_WAIT, reset flop loads 1, lock_loss_count++ (saturating).
  - Else reset_request = 1 -> HOLD, counter cleared, reset flop loads 1.
- Priority: lock loss > reset_request > counter expiry.
- lock_loss_count:
  - Saturates at 255 and never wraps.
  - Cleared only by reset_n.
- Latency:
  - locked sampled high first at edge 1 -> locked_s high after edge 2.
  - reset falls at edge 2 + LOCK_CYCLES + HOLD_CYCLES.
  - Lock loss sampled at edge k -> reset rises after edge k+2.
  - reset_request high at edge k in RUN -> reset = 1 after edge k.
- Glitches: a locked_s low of any length, even one cycle, restarts LOCK_WAIT qualification from 0.
- Mid-operation reset_n assertion: reset = 1 immediately (combinationally via async clear), with all state cleared as above.

Test Plan:
- LOCK_CYCLES=4, HOLD_CYCLES=8; reset_n released, locked held high from before edge 1 -> reset = 1 through edge 13, reset = 0 after edge 14; lock_loss_count = 0.
- Same params; locked pulses high 3 cycles then low, then stays high -> no entry to HOLD during the pulse; reset falls exactly 14 edges after the final rise is first sampled; lock_loss_count = 0.
- In RUN, locked drops for 1 cycle -> reset = 1 two edges after the drop is sampled; lock_loss_count = 1; full 4+8 requalification before reset falls again.
- In RUN, 1-cycle reset_request -> reset = 1 after that edge, reset = 0 exactly 8 edges later; lock_loss_count unchanged.
- In HOLD, locked drops and reset_request is high on the same edge -> LOCK_WAIT taken, lock_loss_count increments, reset stays 1.
- 300 forced lock losses -> lock_loss_count = 255. Then assert reset_n asynchronously mid-HOLD -> reset = 1 and lock_loss_count = 0 with no clock edge.
